// File: rtl/mem_pkg.sv
// Shared memory-port types: request/response payloads packed by the cpu side,
// plus the per-request tracking record used inside the SRAM controller.
package mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } trk_t;

  localparam int unsigned REQ_W  = $bits(mem_req_t);
  localparam int unsigned RESP_W = $bits(mem_resp_t);

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with head-of-queue output taken straight from the
// storage registers; pointers wrap modulo DEPTH, occupancy kept in its own counter.
module sync_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-side endpoint: drives a fixed-latency synchronous SRAM from the
// decoupled request stream and returns one in-order response per request.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REQ_W-1:0]  req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("mem_sram_ctrl: LATENCY must be >= 1");
  end
  if (RESP_DEPTH < 1) begin : g_bad_depth
    $error("mem_sram_ctrl: RESP_DEPTH must be >= 1");
  end

  mem_req_t         req;
  mem_resp_t        push_resp;
  mem_resp_t        head;
  trk_t             pipe_q [LATENCY];
  trk_t             pipe_d [LATENCY];
  trk_t             tail;
  logic             accept;
  logic             in_range;
  logic             push;
  logic             resp_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;

  assign req = req_data;

  // Credits cover both the tracking pipe and the FIFO, so a push can never find it full.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i].valid);
    end
  end

  assign req_ready = rst && (({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(RESP_DEPTH));

  always_comb begin
    in_range   = ((req.addr >> (ADDR_W + 2)) == '0);
    accept     = req_valid && req_ready;
    sram_en    = accept && in_range;
    sram_we    = accept && req.we;
    sram_be    = accept ? req.be : '0;
    sram_addr  = accept ? req.addr[ADDR_W+1:2] : '0;
    sram_wdata = accept ? req.wdata : '0;
  end

  always_comb begin
    pipe_d[0] = '{valid: accept, we: req.we, err: !in_range};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  always_comb begin
    tail            = pipe_q[LATENCY-1];
    push            = tail.valid;
    push_resp.err   = tail.err;
    push_resp.rdata = (tail.we || tail.err) ? '0 : sram_rdata;
  end

  assign resp_pop = resp_valid && resp_ready;

  sync_fifo #(
    .T     (mem_resp_t),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_resp),
    .pop       (resp_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign resp_data  = head;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl with a behavioural 1-cycle SRAM and an
// in-order response scoreboard.
module tb_mem_sram_ctrl;
  import mem_pkg::*;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned LATENCY    = 1;
  localparam int unsigned RESP_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  mem_req_t          req_s;
  logic              resp_valid;
  logic              resp_ready;
  logic [RESP_W-1:0] resp_data;
  logic              sram_en;
  logic              sram_we;
  logic [3:0]        sram_be;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  always #5 clk = ~clk;

  mem_sram_ctrl #(
    .ADDR_W     (ADDR_W),
    .LATENCY    (LATENCY),
    .RESP_DEPTH (RESP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_s),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  logic [31:0] sram_mem [1024];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_acc   = 0;
  int          n_resp  = 0;
  int          acc_cyc = 0;
  int          hs_cyc  = -1;
  int          first_hs_cyc = -1;
  int          last_hs_cyc  = -1;
  int          stale   = 0;
  logic        acc;
  logic        held_v  = 1'b0;
  mem_resp_t   held;
  mem_resp_t   cur_exp;
  mem_resp_t   sb [$];
  logic [31:0] shadow [1024];
  vec_t        vecs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic mem_resp_t model(input logic we, input logic [31:0] addr);
    mem_resp_t r;
    if ((addr >> 12) != 0)  r = '{rdata: '0, err: 1'b1};
    else if (we)            r = '{rdata: '0, err: 1'b0};
    else                    r = '{rdata: shadow[addr[11:2]], err: 1'b0};
    return r;
  endfunction

  // One clock: observe at the negedge, return just after the next posedge.
  task automatic tick();
    mem_resp_t r;
    mem_resp_t e;
    logic      in_rng;
    @(negedge clk);
    cyc++;
    acc = req_valid && req_ready;
    if (acc) begin
      n_acc++;
      acc_cyc = cyc;
      in_rng  = ((req_s.addr >> 12) == 0);
      chk("sram_en", 64'(sram_en), 64'(in_rng));
      if (in_rng) begin
        chk("sram_addr", 64'(sram_addr), 64'(req_s.addr[11:2]));
        chk("sram_we", 64'(sram_we), 64'(req_s.we));
        if (req_s.we) begin
          for (int b = 0; b < 4; b++) begin
            if (req_s.be[b]) shadow[req_s.addr[11:2]][8*b +: 8] = req_s.wdata[8*b +: 8];
          end
        end
      end
      sb.push_back(cur_exp);
    end
    if (resp_valid && resp_ready) begin
      r = resp_data;
      hs_cyc = cyc;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      if (sb.size() == 0) begin
        stale++;
      end else begin
        e = sb.pop_front();
        n_resp++;
        chk("resp_data", 64'({r.rdata, r.err}), 64'({e.rdata, e.err}));
      end
    end
    if (resp_valid && !resp_ready) begin
      if (held_v) chk("resp_stable", 64'(resp_data), 64'(held));
      held_v = 1'b1;
      held   = resp_data;
    end else begin
      held_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input mem_resp_t exp);
    req_valid = 1'b1;
    req_s     = '{addr: addr, wdata: wdata, be: be, we: we};
    cur_exp   = exp;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL accept_timeout: addr 0x%0h not accepted in 20 cycles, required acceptance", addr);
  endtask

  task automatic send_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    send(we, addr, wdata, be, model(we, addr));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n0;
    int r0;
    int c0;
    rst        = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_s      = '{addr: 32'h40, wdata: 32'h1234_5678, be: 4'hF, we: 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_sram_drive", 64'({sram_we, sram_be, sram_addr, sram_wdata}), 64'd0);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'd1);

    // write/read, partial write, out-of-range, address alignment and top word
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hFF22_FF44, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h600D_F00D, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h600D_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0000_0000, 1'b1});
    foreach (vecs[i]) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
           '{rdata: vecs[i].exp_rdata, err: vecs[i].exp_err});
    end
    drain();

    // read latency with an empty response queue
    hs_cyc = -1;
    send_m(1'b0, 32'h10, 32'h0, 4'h0);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && hs_cyc < 0; i++) tick();
    chk("read_latency", 64'(hs_cyc - acc_cyc), 64'd2);
    drain();

    // backpressure: credits stop acceptance at RESP_DEPTH outstanding
    for (int i = 0; i < 6; i++) send_m(1'b1, 32'h100 + 32'(4*i), 32'hB000_0000 + 32'(i), 4'hF);
    drain();
    resp_ready = 1'b0;
    n0 = n_acc;
    r0 = n_resp;
    for (int i = 0; i < 4; i++) send_m(1'b0, 32'h100 + 32'(4*i), 32'h0, 4'h0);
    req_valid = 1'b1;
    req_s     = '{addr: 32'h110, wdata: '0, be: '0, we: 1'b0};
    cur_exp   = model(1'b0, 32'h110);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    chk("bp_accepted", 64'(n_acc - n0), 64'd4);
    resp_ready = 1'b1;
    send_m(1'b0, 32'h110, 32'h0, 4'h0);
    send_m(1'b0, 32'h114, 32'h0, 4'h0);
    drain();
    chk("bp_resp_count", 64'(n_resp - r0), 64'd6);

    // streaming: 16 back-to-back reads
    for (int i = 0; i < 16; i++) send_m(1'b1, 32'h200 + 32'(4*i), 32'h5A5A_5A5A ^ (32'h0101_0101 * 32'(i)), 4'hF);
    drain();
    first_hs_cyc = -1;
    r0 = n_resp;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send_m(1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0);
    chk("stream_no_stall", 64'(cyc - c0), 64'd16);
    drain();
    chk("stream_resp_count", 64'(n_resp - r0), 64'd16);
    chk("stream_resp_span", 64'(last_hs_cyc - first_hs_cyc), 64'd15);

    // reset with three requests outstanding
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_m(1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    held_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_release_ready", 64'(req_ready), 64'd1);
    resp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("no_stale_resp", 64'(stale), 64'd0);
    send_m(1'b0, 32'h204, 32'h0, 4'h0);
    drain();
    chk("final_stale", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
